ddr_latency_responder: RTL and testbench
========================================

DDR_LATENCY_RESPONDER -- requirements
Module: ddr_latency_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384: memory depth in 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 4, legal 1..16: read-acceptance-to-valid delay in cycles.
REQ-003 SHALL have parameter REFRESH_PERIOD, default 1024: cycles between refresh windows.
REQ-004 SHALL have parameter REFRESH_CYCLES, default 8, legal 1..REFRESH_PERIOD-1: refresh window length.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-007 SHALL have port ddr_rd_req  input  1  read request, sampled each cycle.
REQ-008 SHALL have port ddr_wr_req  input  1  write request, sampled each cycle.
REQ-009 SHALL have port ddr_addr  input  32  word address (not byte address).
REQ-010 SHALL have port ddr_wr_data  input  32  write data.
REQ-011 SHALL have port ddr_wr_strb  input  4  byte enables; bit i covers bits 8i+7..8i.
REQ-012 SHALL have port ddr_ready  output  1  request acceptance enable, registered.
REQ-013 SHALL have port ddr_rd_valid  output  1  one-cycle pulse per returned read word.
REQ-014 SHALL have port ddr_rd_data  output  32  read data, meaningful only while ddr_rd_valid=1.
REQ-015 SHALL have port ddr_err  output  1  sticky error flag.
REQ-016 SHALL hold storage in an unpacked array named mem, 32 bits x MEM_WORDS, index 0 = word 0, so a bench can preload it hierarchically with $readmemh.

Function
REQ-017 Acceptance: a request SHALL be accepted in a cycle where (ddr_rd_req|ddr_wr_req)=1 and ddr_ready=1; requests while ddr_ready=0 SHALL be dropped silently, with no queuing and no error.
REQ-018 Write: an accepted write with ddr_addr<MEM_WORDS SHALL update only the strobed bytes of mem[ddr_addr] at that clock edge.
REQ-019 Read: an accepted read SHALL capture mem[ddr_addr] at acceptance, including any write committed at an earlier edge, and present it on ddr_rd_data with ddr_rd_valid=1 exactly LATENCY cycles later.
REQ-020 Pipelining: one read SHALL be acceptable every cycle; returns SHALL be in acceptance order via a LATENCY-stage valid+data delay line, with no bubbles and no loss.
REQ-021 Simultaneous ddr_rd_req and ddr_wr_req in an accepted cycle: the write SHALL be performed, the read discarded (no rd_valid), and ddr_err set.
REQ-022 Out-of-range (ddr_addr>=MEM_WORDS): writes SHALL be ignored; reads SHALL return 32'hDEADBEEF at normal latency; both SHALL set ddr_err.
REQ-023 ddr_err SHALL remain 1 until reset.
REQ-024 FSM states SHALL be ACTIVE (ddr_ready=1) and REFRESH (ddr_ready=0).
REQ-025 Refresh counter SHALL increment every cycle in ACTIVE; at value REFRESH_PERIOD-1, the FSM SHALL enter REFRESH on the next edge and the counter SHALL clear.
REQ-026 REFRESH SHALL last exactly REFRESH_CYCLES cycles, then return to ACTIVE.
REQ-027 Reads in flight at refresh entry SHALL complete on schedule during REFRESH.
REQ-028 ddr_rd_valid SHALL be 0 in every cycle not scheduled by an accepted in-range or out-of-range read.

Reset
REQ-029 While resetn=0 at a clock edge: ddr_ready=0, ddr_rd_valid=0, ddr_rd_data=0, ddr_err=0, delay line cleared, refresh counter=0, state=ACTIVE on the first edge with resetn=1.
REQ-030 mem contents SHALL NOT be altered by reset; preload done during reset SHALL survive.
REQ-031 Reads in flight when reset asserts SHALL be discarded, with no rd_valid after reset release.

Verification
REQ-032 Preload mem[5]=32'h12345678; read addr 5 accepted at cycle T -> rd_valid=1, rd_data=32'h12345678 at cycle T+4 only.
REQ-033 Write addr 7 data 32'hAABBCCDD strb 4'b0101 over mem[7]=0, then read 7 next cycle -> returns 32'h00BB00DD.
REQ-034 Back-to-back reads addr 0..7 on 8 consecutive cycles -> 8 consecutive rd_valid pulses, data in order.
REQ-035 Read addr 20000 -> 32'hDEADBEEF after 4 cycles, ddr_err=1 and held; rd+wr together -> write applied, no rd_valid.
REQ-036 Run 1024 cycles after reset -> ddr_ready=0 for exactly 8 cycles; requests then dropped; a read accepted 2 cycles before still returns.
REQ-037 Assert resetn=0 with 3 reads in flight -> no rd_valid afterwards; mem unchanged, verified by readback.

Source files
------------

// File: rtl/ddr_latency_responder.sv
// Behavioural DDR stand-in: byte-strobed writes, pipelined reads returned LATENCY cycles after acceptance.
// No request buffering: ddr_ready drops for REFRESH_CYCLES every refresh window and requests are then dropped.
module ddr_latency_responder #(
    parameter int MEM_WORDS      = 16384,
    parameter int LATENCY        = 4,
    parameter int REFRESH_PERIOD = 1024,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ddr_rd_req,
    input  logic        ddr_wr_req,
    input  logic [31:0] ddr_addr,
    input  logic [31:0] ddr_wr_data,
    input  logic [3:0]  ddr_wr_strb,
    output logic        ddr_ready,
    output logic        ddr_rd_valid,
    output logic [31:0] ddr_rd_data,
    output logic        ddr_err
);
    localparam int            AW           = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int            CW           = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [CW-1:0] PERIOD_LAST  = CW'(REFRESH_PERIOD - 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [31:0]   MEM_LIMIT    = 32'(MEM_WORDS);
    localparam logic [31:0]   OOR_DATA     = 32'hDEADBEEF;

    typedef enum logic {ACTIVE, REFRESH} state_t;

    logic [31:0] mem [0:MEM_WORDS-1];

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [LATENCY-1:0]  vld_q, vld_d;
    logic [31:0]         dat_q [LATENCY];
    logic [31:0]         dat_d [LATENCY];

    logic          accept;
    logic          in_range;
    logic          rd_acc;
    logic          wr_en;
    logic [AW-1:0] mem_idx;
    logic [31:0]   rd_word;

    assign accept   = ready_q & (ddr_rd_req | ddr_wr_req);
    assign in_range = (ddr_addr < MEM_LIMIT);
    assign mem_idx  = ddr_addr[AW-1:0];
    // A read colliding with a write loses; the write still commits.
    assign rd_acc   = accept & ddr_rd_req & ~ddr_wr_req;
    assign wr_en    = resetn & accept & ddr_wr_req & in_range;
    assign rd_word  = in_range ? mem[mem_idx] : OOR_DATA;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            ACTIVE: begin
                if (cnt_q == PERIOD_LAST) begin
                    state_d = REFRESH;
                    cnt_d   = '0;
                end
            end
            REFRESH: begin
                if (cnt_q == REFRESH_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ACTIVE;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == ACTIVE);
        err_d   = err_q | (accept & ((ddr_rd_req & ddr_wr_req) | ~in_range));

        vld_d[0] = rd_acc;
        dat_d[0] = rd_word;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Storage is deliberately outside reset so preloaded contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ddr_wr_strb[b]) begin
                    mem[mem_idx][8*b +: 8] <= ddr_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign ddr_ready    = ready_q;
    assign ddr_rd_valid = vld_q[LATENCY-1];
    assign ddr_rd_data  = dat_q[LATENCY-1];
    assign ddr_err      = err_q;

endmodule

// File: tb/tb_ddr_latency_responder.sv
// Bench for ddr_latency_responder: directed table, corner sequences, then random traffic against a queue-based model.
module tb_ddr_latency_responder;
    localparam int MEM_WORDS      = 16384;
    localparam int LATENCY        = 4;
    localparam int REFRESH_PERIOD = 1024;
    localparam int REFRESH_CYCLES = 8;

    logic        clk;
    logic        rstn;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic        ddr_ready, ddr_rd_valid, ddr_err;
    logic [31:0] ddr_rd_data;

    ddr_latency_responder #(
        .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY),
        .REFRESH_PERIOD(REFRESH_PERIOD), .REFRESH_CYCLES(REFRESH_CYCLES)
    ) dut (
        .clk(clk), .resetn(rstn), .ddr_rd_req(rd), .ddr_wr_req(wr),
        .ddr_addr(addr), .ddr_wr_data(wdata), .ddr_wr_strb(strb),
        .ddr_ready(ddr_ready), .ddr_rd_valid(ddr_rd_valid),
        .ddr_rd_data(ddr_rd_data), .ddr_err(ddr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] d; } ret_t;
    typedef struct {
        logic        is_rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl_mem [logic [31:0]];
    ret_t        exp_q [$];
    logic        m_ready = 1'b0;
    logic        m_err = 1'b0;
    int          rel = 0;
    int          ecount = 0;
    logic        last_vld = 1'b0;
    logic [31:0] last_dat = '0;
    int          vld_seen = 0;
    int          run = 0;
    int          max_run = 0;
    logic [31:0] obs_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, ecount);
        end
    endtask

    // Ready after the k-th edge since reset release: one ACTIVE stretch of
    // REFRESH_PERIOD cycles counts the reset-release cycle, then fixed windows.
    function automatic logic ready_at(input int k);
        int m;
        if (k < REFRESH_PERIOD - 1) return 1'b1;
        m = (k - (REFRESH_PERIOD - 1)) % (REFRESH_PERIOD + REFRESH_CYCLES);
        return (m >= REFRESH_CYCLES);
    endfunction

    task automatic tick();
        logic        acc, inr, exp_v;
        logic [31:0] old;
        ret_t        e;
        acc = rstn && m_ready && (rd || wr);
        inr = (addr < 32'(MEM_WORDS));
        old = mdl_mem.exists(addr) ? mdl_mem[addr] : 32'hx;
        @(posedge clk);
        ecount++;
        if (!rstn) begin
            exp_q.delete();
            m_err   = 1'b0;
            m_ready = 1'b0;
            rel     = 0;
        end else begin
            if (acc) begin
                if (wr && inr) begin
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) old[8*b +: 8] = wdata[8*b +: 8];
                    mdl_mem[addr] = old;
                end
                if (rd && !wr) begin
                    e.due = ecount + LATENCY - 1;
                    e.d   = inr ? old : 32'hDEADBEEF;
                    exp_q.push_back(e);
                end
                if ((rd && wr) || !inr) m_err = 1'b1;
            end
            m_ready = ready_at(rel);
            rel++;
        end
        #1;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == ecount);
        check("ready", 32'(ddr_ready), 32'(m_ready));
        check("rd_valid", 32'(ddr_rd_valid), 32'(exp_v));
        check("err", 32'(ddr_err), 32'(m_err));
        if (exp_v) begin
            check("rd_data", ddr_rd_data, exp_q[0].d);
            void'(exp_q.pop_front());
        end
        if (!rstn) check("rst_data", ddr_rd_data, 32'h0);
        last_vld = ddr_rd_valid;
        last_dat = ddr_rd_data;
        if (ddr_rd_valid) begin
            vld_seen++;
            obs_q.push_back(ddr_rd_data);
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; rd = 1'b0; wr = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr = 1'b1; addr = a; wdata = d; strb = s;
        tick();
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        int          lat;
        logic [31:0] got;
        lat = -1;
        got = 32'hx;
        rd = 1'b1; addr = a;
        tick();
        rd = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            if (last_vld && lat < 0) begin
                lat = c;
                got = last_dat;
            end
        end
        check({nm, "_lat"}, 32'(lat), 32'(LATENCY));
        check({nm, "_dat"}, got, exp);
    endtask

    vec_t        tbl [9];
    logic [31:0] b2b_exp [8];
    int          n, low, v0;
    logic [31:0] ra;
    logic [31:0] pick [5];

    initial begin
        tbl[0] = '{1'b1, 32'd5,     32'h0,        4'h0,    32'h12345678, 1'b0};
        tbl[1] = '{1'b0, 32'd7,     32'hAABBCCDD, 4'b0101, 32'h0,        1'b0};
        tbl[2] = '{1'b1, 32'd7,     32'h0,        4'h0,    32'h00BB00DD, 1'b0};
        tbl[3] = '{1'b0, 32'd7,     32'h11223344, 4'b1010, 32'h0,        1'b0};
        tbl[4] = '{1'b1, 32'd7,     32'h0,        4'h0,    32'h11BB33DD, 1'b0};
        tbl[5] = '{1'b0, 32'd3,     32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0};
        tbl[6] = '{1'b1, 32'd3,     32'h0,        4'h0,    32'hC0DE0003, 1'b0};
        tbl[7] = '{1'b1, 32'd63,    32'h0,        4'h0,    32'hC0DE003F, 1'b0};
        tbl[8] = '{1'b1, 32'd16383, 32'h0,        4'h0,    32'h7E573FFF, 1'b0};
        b2b_exp = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                    32'hC0DE0004, 32'h12345678, 32'hC0DE0006, 32'h11BB33DD};
        pick = '{32'd16383, 32'd16384, 32'd20000, 32'hFFFFFFFF, 32'd0};

        rstn = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; strb = '0;
        for (int i = 0; i < 64; i++) begin
            dut.mem[i] = 32'hC0DE0000 | 32'(i);
            mdl_mem[32'(i)] = 32'hC0DE0000 | 32'(i);
        end
        dut.mem[5] = 32'h12345678;      mdl_mem[32'd5] = 32'h12345678;
        dut.mem[7] = 32'h0;             mdl_mem[32'd7] = 32'h0;
        dut.mem[16383] = 32'h7E573FFF;  mdl_mem[32'd16383] = 32'h7E573FFF;

        do_reset();

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].is_rd) do_read(tbl[i].a, tbl[i].exp_dat, $sformatf("tbl%0d_rd", i));
            else              do_write(tbl[i].a, tbl[i].d, tbl[i].s);
            check($sformatf("tbl%0d_err", i), 32'(ddr_err), 32'(tbl[i].exp_err));
        end

        // Back-to-back reads: expect an unbroken run of 8 returns in order.
        obs_q.delete();
        max_run = 0;
        rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr = 32'(i);
            tick();
        end
        rd = 1'b0;
        repeat (6) tick();
        check("b2b_count", 32'(obs_q.size()), 32'd8);
        check("b2b_run", 32'(max_run), 32'd8);
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            check($sformatf("b2b_dat%0d", i), obs_q[i], b2b_exp[i]);

        // Refresh entry with a read accepted two cycles earlier.
        n = 0;
        while (rel < REFRESH_PERIOD - 3 && n < 3000) begin
            tick();
            n++;
        end
        rd = 1'b1; addr = 32'd1;
        tick();
        rd = 1'b0;
        v0 = vld_seen;
        n = 0;
        while (ddr_ready && n < 10) begin
            tick();
            n++;
        end
        check("refresh_entry", 32'(n < 10), 32'd1);
        low = 0;
        while (!ddr_ready && low < 20) begin
            rd = ~low[0]; wr = low[0];
            addr = low[0] ? 32'd11 : 32'd2;
            wdata = 32'hFFFFFFFF; strb = 4'hF;
            tick();
            low++;
        end
        rd = 1'b0; wr = 1'b0;
        check("refresh_len", 32'(low), 32'(REFRESH_CYCLES));
        repeat (6) tick();
        check("refresh_inflight", 32'(vld_seen - v0), 32'd1);
        do_read(32'd11, 32'hC0DE000B, "dropped_wr");

        // Out-of-range accesses and sticky error.
        do_read(32'd20000, 32'hDEADBEEF, "oor_rd");
        check("oor_err", 32'(ddr_err), 32'd1);
        do_read(32'd16384, 32'hDEADBEEF, "oor_edge");
        do_write(32'd20000, 32'h0BADF00D, 4'hF);
        repeat (5) tick();
        check("err_sticky", 32'(ddr_err), 32'd1);

        // Reset with three reads in flight.
        rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 32'(i);
            tick();
        end
        rd = 1'b0;
        v0 = vld_seen;
        do_reset();
        repeat (10) tick();
        check("flush_vld", 32'(vld_seen - v0), 32'd0);
        check("flush_err", 32'(ddr_err), 32'd0);
        do_read(32'd0, 32'hC0DE0000, "keep0");
        do_read(32'd2, 32'hC0DE0002, "keep2");
        do_read(32'd5, 32'h12345678, "keep5");
        do_read(32'd7, 32'h11BB33DD, "keep7");

        // Read and write together: write wins, read is dropped, error raised.
        rd = 1'b1; wr = 1'b1; addr = 32'd12; wdata = 32'h5A5A5A5A; strb = 4'hF;
        tick();
        rd = 1'b0; wr = 1'b0;
        v0 = vld_seen;
        repeat (6) tick();
        check("rdwr_no_vld", 32'(vld_seen - v0), 32'd0);
        check("rdwr_err", 32'(ddr_err), 32'd1);
        do_read(32'd12, 32'h5A5A5A5A, "rdwr_wr");

        // Random traffic spanning a refresh window.
        do_reset();
        for (int i = 0; i < 1300; i++) begin
            n = int'($urandom_range(0, 9));
            rd = (n <= 3) || (n == 7);
            wr = (n >= 4 && n <= 7);
            if ($urandom_range(0, 7) == 0) ra = pick[$urandom_range(0, 4)];
            else                            ra = 32'($urandom_range(0, 63));
            addr = ra;
            wdata = $urandom;
            strb = 4'($urandom_range(0, 15));
            tick();
        end
        rd = 1'b0; wr = 1'b0;
        repeat (8) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
